// File: rtl/npc_pkg.sv
// npc_pkg: definitions shared by the NPC memory arbiter sources.
//   arb_state_e    - arbiter FSM state encoding (IDLE / SEND / WAIT)
//   OWNER_IFU/LSU  - encoding of the requester that owns the outstanding access
//   STARVE_W       - width of the IFU starvation counter
package npc_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_SEND = 2'd1,
    ARB_WAIT = 2'd2
  } arb_state_e;

  localparam logic OWNER_IFU = 1'b0;
  localparam logic OWNER_LSU = 1'b1;

  localparam int STARVE_W = 4;

endpackage

// File: rtl/npc_arb_pick.sv
// npc_arb_pick: winner select between IFU and LSU plus the IFU starvation
// counter. LSU normally wins; once LSU_MAX consecutive LSU grants have been
// given while the IFU was waiting, the IFU wins the next contended slot.
//   clk, rst       - clock, synchronous active-high reset
//   arb_en         - arbiter is able to accept a request this cycle
//   ifu_req_valid  - IFU is requesting
//   lsu_req_valid  - LSU is requesting
//   ifu_grant      - IFU request accepted this cycle
//   lsu_grant      - LSU request accepted this cycle
module npc_arb_pick
  import npc_pkg::*;
#(
  parameter int LSU_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic arb_en,
  input  logic ifu_req_valid,
  input  logic lsu_req_valid,
  output logic ifu_grant,
  output logic lsu_grant
);

  localparam logic [STARVE_W-1:0] LSU_MAX_C = STARVE_W'(LSU_MAX);

  logic [STARVE_W-1:0] starve_q, starve_d;
  logic                lsu_may_win;

  always_comb begin
    lsu_may_win = !ifu_req_valid || (starve_q < LSU_MAX_C);
    lsu_grant   = arb_en && lsu_req_valid && lsu_may_win;
    ifu_grant   = arb_en && ifu_req_valid && !lsu_grant;

    starve_d = starve_q;
    if (lsu_grant) begin
      // Only count LSU grants that actually kept a waiting IFU out.
      if (ifu_req_valid) begin
        starve_d = (starve_q >= LSU_MAX_C) ? LSU_MAX_C : starve_q + 1'b1;
      end else begin
        starve_d = '0;
      end
    end else if (ifu_grant) begin
      starve_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

endmodule

// File: rtl/npc_mem_arbiter.sv
// npc_mem_arbiter: shares the single NPC memory port between the IFU
// (reads only) and the LSU (loads and stores). One access is outstanding at
// a time; the response is routed back to the requester that owns it.
//   clk, rst                      - clock, synchronous active-high reset
//   ifu_req_valid/ready, ifu_addr - IFU fetch request handshake
//   ifu_resp_valid, ifu_rdata     - IFU read data (one-cycle pulse)
//   lsu_req_valid/ready, lsu_*    - LSU request handshake and payload
//   lsu_resp_valid, lsu_rdata     - LSU completion pulse and load data
//   mem_req_valid/ready, mem_*    - registered request towards memory
//   mem_resp_valid, mem_rdata     - memory response (no backpressure)
module npc_mem_arbiter
  import npc_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int LSU_MAX = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ifu_req_valid,
  output logic            ifu_req_ready,
  input  logic [AW-1:0]   ifu_addr,
  output logic            ifu_resp_valid,
  output logic [DW-1:0]   ifu_rdata,
  input  logic            lsu_req_valid,
  output logic            lsu_req_ready,
  input  logic [AW-1:0]   lsu_addr,
  input  logic            lsu_wen,
  input  logic [DW-1:0]   lsu_wdata,
  input  logic [DW/8-1:0] lsu_wmask,
  output logic            lsu_resp_valid,
  output logic [DW-1:0]   lsu_rdata,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [AW-1:0]   mem_addr,
  output logic            mem_wen,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_wmask,
  input  logic            mem_resp_valid,
  input  logic [DW-1:0]   mem_rdata
);

  arb_state_e      state_q, state_d;
  logic            owner_q, owner_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic            mem_wen_q, mem_wen_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DW/8-1:0] mem_wmask_q, mem_wmask_d;

  logic arb_en;
  logic ifu_grant;
  logic lsu_grant;
  logic in_wait;
  logic resp_fire;

  // Accepting is only possible in IDLE; holding off during rst keeps the
  // handshake outputs quiet while the block is being reset.
  assign arb_en = (state_q == ARB_IDLE) && !rst;

  npc_arb_pick #(
    .LSU_MAX(LSU_MAX)
  ) u_pick (
    .clk          (clk),
    .rst          (rst),
    .arb_en       (arb_en),
    .ifu_req_valid(ifu_req_valid),
    .lsu_req_valid(lsu_req_valid),
    .ifu_grant    (ifu_grant),
    .lsu_grant    (lsu_grant)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    mem_addr_d  = mem_addr_q;
    mem_wen_d   = mem_wen_q;
    mem_wdata_d = mem_wdata_q;
    mem_wmask_d = mem_wmask_q;
    case (state_q)
      ARB_IDLE: begin
        if (lsu_grant) begin
          state_d     = ARB_SEND;
          owner_d     = OWNER_LSU;
          mem_addr_d  = lsu_addr;
          mem_wen_d   = lsu_wen;
          mem_wdata_d = lsu_wdata;
          mem_wmask_d = lsu_wmask;
        end else if (ifu_grant) begin
          // Fetches are always plain reads: no write enable, no byte lanes.
          state_d     = ARB_SEND;
          owner_d     = OWNER_IFU;
          mem_addr_d  = ifu_addr;
          mem_wen_d   = 1'b0;
          mem_wdata_d = '0;
          mem_wmask_d = '0;
        end
      end
      ARB_SEND: begin
        if (mem_req_ready) begin
          state_d = ARB_WAIT;
        end
      end
      ARB_WAIT: begin
        if (mem_resp_valid) begin
          state_d = ARB_IDLE;
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ARB_IDLE;
      owner_q     <= OWNER_IFU;
      mem_addr_q  <= '0;
      mem_wen_q   <= 1'b0;
      mem_wdata_q <= '0;
      mem_wmask_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      mem_addr_q  <= mem_addr_d;
      mem_wen_q   <= mem_wen_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wmask_q <= mem_wmask_d;
    end
  end

  // A response is only meaningful while waiting; strays elsewhere are dropped.
  assign in_wait   = (state_q == ARB_WAIT);
  assign resp_fire = in_wait && mem_resp_valid;

  assign ifu_req_ready  = ifu_grant;
  assign lsu_req_ready  = lsu_grant;
  assign mem_req_valid  = (state_q == ARB_SEND);
  assign mem_addr       = mem_addr_q;
  assign mem_wen        = mem_wen_q;
  assign mem_wdata      = mem_wdata_q;
  assign mem_wmask      = mem_wmask_q;

  assign ifu_resp_valid = resp_fire && (owner_q == OWNER_IFU);
  assign lsu_resp_valid = resp_fire && (owner_q == OWNER_LSU);
  assign ifu_rdata      = (in_wait && (owner_q == OWNER_IFU)) ? mem_rdata : '0;
  assign lsu_rdata      = (in_wait && (owner_q == OWNER_LSU)) ? mem_rdata : '0;

endmodule
